ram_hs_burst_reader: RTL and testbench



---
 rtl/ram_hs_burst_reader.sv | 181 ++++++++++++++++++
 tb/tb_ram_hs_burst_reader.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_hs_burst_reader.sv
// Burst read initiator: splits one (addr, len) command into single-word requests to a
// handshake SRAM and streams the in-order responses through a credit-protected FIFO.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a burst command
// ISSUE | sending read requests while FIFO credit is available
// DRAIN | all requests sent, waiting for the last word to leave the out port
// DONE  | one-cycle done pulse, then back to IDLE
module ram_hs_burst_reader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 6,
    parameter int LEN_W      = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_issued;
    logic [LEN_W-1:0]    r_received;
    logic [ADDR_W-1:0]   r_araddr;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;

    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_last;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_outstanding;

    logic                w_credit;
    logic                w_arvalid;
    logic                w_ar_hs;
    logic                w_push;
    logic                w_pop;
    logic                w_head_last;
    logic                w_recv_last;

    // Words already buffered plus words still in flight must fit in the FIFO.
    assign w_credit    = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign w_arvalid   = (r_state == S_ISSUE) && w_credit;
    assign w_ar_hs     = w_arvalid && arready;
    assign w_push      = rvalid && (r_state != S_IDLE);
    assign w_pop       = (r_count != '0) && out_ready;
    assign w_head_last = r_mem_last[r_rd_ptr];
    assign w_recv_last = (r_received + LEN_W'(1)) == r_len;

    assign cmd_ready = r_cmd_ready;
    assign arvalid   = w_arvalid;
    assign araddr    = r_araddr;
    assign rready    = 1'b1;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign out_last  = (r_count != '0) && w_head_last;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_araddr    <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_push) begin
                r_received <= r_received + LEN_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_len       <= cmd_len;
                        r_araddr    <= cmd_addr;
                        r_issued    <= '0;
                        r_received  <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_ar_hs) begin
                        r_araddr <= r_araddr + ADDR_W'(1);
                        r_issued <= r_issued + LEN_W'(1);
                        if ((r_issued + LEN_W'(1)) == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            case ({w_ar_hs, w_push})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Storage needs no reset: a word is only visible once the count covers it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= rdata;
            r_mem_last[r_wr_ptr] <= w_recv_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && r_count == CNT_W'(FIFO_DEPTH)));
            assert (!(rvalid && r_state == S_IDLE));
        end
    end

endmodule

// File: tb/tb_ram_hs_burst_reader.sv
// Bench for ram_hs_burst_reader: a 1-cycle handshake RAM model, a negedge monitor
// collecting handshakes, and per-scenario tasks comparing against a scoreboard.
module tb_ram_hs_burst_reader;

    localparam int DATA_W     = 128;
    localparam int ADDR_W     = 6;
    localparam int LEN_W      = 7;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              arvalid;
    logic              arready = 1'b1;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [ADDR_W-1:0] q_exp_ar[$];
    logic [DATA_W:0]   q_exp_out[$];
    logic [ADDR_W-1:0] q_obs_ar[$];
    int                q_obs_ar_cyc[$];
    logic [DATA_W:0]   q_obs_out[$];
    int                q_obs_out_cyc[$];

    ram_hs_burst_reader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = {26'b0, a};
        return {32'hCAFE_0000 + x, 32'h1234_0000 + x * 32'd7, 32'hFFFF_FFFF - x, x};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data one cycle after each accepted request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= arvalid && arready;
            rdata  <= word_of(araddr);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (arvalid && arready) begin
                q_obs_ar.push_back(araddr);
                q_obs_ar_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                q_obs_out.push_back({out_last, out_data});
                q_obs_out_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        q_exp_ar.delete();
        q_exp_out.delete();
        q_obs_ar.delete();
        q_obs_ar_cyc.delete();
        q_obs_out.delete();
        q_obs_out_cyc.delete();
    endtask

    task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                             output int acc_cyc);
        logic ok;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        for (int i = 0; i < int'(len); i++) begin
            q_exp_ar.push_back(a + ADDR_W'(i));
            q_exp_out.push_back({(i == int'(len) - 1), word_of(a + ADDR_W'(i))});
        end
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        acc_cyc   = cyc;
        n_checks++;
        if (ok !== 1'b1) begin
            n_errors++;
            $display("FAIL cmd_accept: cmd_ready=%0b, required 1 within 50 cycles", ok);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int start;
        int t;
        start = done_cnt;
        t = 0;
        while (done_cnt == start && t < budget) begin
            tick();
            t++;
        end
        n_checks++;
        if (done_cnt == start) begin
            n_errors++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, arvalid, out_valid, out_last, busy, done, rready} !== 7'b1000001) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b, required 1000001",
                     {cmd_ready, arvalid, out_valid, out_last, busy, done, rready});
        end
        n_checks++;
        if (araddr !== '0) begin
            n_errors++;
            $display("FAIL reset_araddr: got %0d, required 0", araddr);
        end
        tick();
    endtask

    task automatic test_basic();
        int acc;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W:0] eo;
        clear_all();
        arready = 1'b1;
        out_ready = 1'b1;
        issue_cmd(6'd5, 7'd3, acc);
        wait_done(50, "basic");
        n_checks++;
        if (q_obs_ar.size() != 3 || q_obs_out.size() != 3) begin
            n_errors++;
            $display("FAIL basic_counts: ar=%0d out=%0d, required 3 and 3", q_obs_ar.size(), q_obs_out.size());
        end else begin
            n_checks++;
            if (q_obs_ar_cyc[0] != acc || q_obs_ar_cyc[1] != acc + 1 || q_obs_ar_cyc[2] != acc + 2) begin
                n_errors++;
                $display("FAIL basic_ar_timing: cycles %0d %0d %0d, required %0d %0d %0d",
                         q_obs_ar_cyc[0], q_obs_ar_cyc[1], q_obs_ar_cyc[2], acc, acc + 1, acc + 2);
            end
            n_checks++;
            if (q_obs_out_cyc[0] != q_obs_ar_cyc[0] + 2) begin
                n_errors++;
                $display("FAIL basic_latency: first word at %0d, required %0d", q_obs_out_cyc[0], q_obs_ar_cyc[0] + 2);
            end
            n_checks++;
            if (done_cyc != q_obs_out_cyc[2] + 1) begin
                n_errors++;
                $display("FAIL basic_done_cycle: done at %0d, required %0d", done_cyc, q_obs_out_cyc[2] + 1);
            end
        end
        while (q_exp_ar.size() != 0 && q_obs_ar.size() != 0) begin
            ea = q_exp_ar.pop_front();
            n_checks++;
            if (q_obs_ar[0] !== ea) begin
                n_errors++;
                $display("FAIL basic_araddr: got %0d, required %0d", q_obs_ar[0], ea);
            end
            void'(q_obs_ar.pop_front());
        end
        while (q_exp_out.size() != 0 && q_obs_out.size() != 0) begin
            eo = q_exp_out.pop_front();
            n_checks++;
            if (q_obs_out[0] !== eo) begin
                n_errors++;
                $display("FAIL basic_out: got last=%0b data=%h, required last=%0b data=%h",
                         q_obs_out[0][DATA_W], q_obs_out[0][DATA_W-1:0], eo[DATA_W], eo[DATA_W-1:0]);
            end
            void'(q_obs_out.pop_front());
        end
    endtask

    task automatic test_wrap();
        int acc;
        logic [ADDR_W-1:0] wrap_seq[4];
        logic [DATA_W:0] eo;
        wrap_seq = '{6'd62, 6'd63, 6'd0, 6'd1};
        clear_all();
        issue_cmd(6'd62, 7'd4, acc);
        wait_done(50, "wrap");
        n_checks++;
        if (q_obs_ar.size() != 4) begin
            n_errors++;
            $display("FAIL wrap_ar_count: got %0d, required 4", q_obs_ar.size());
        end
        for (int i = 0; i < 4 && i < q_obs_ar.size(); i++) begin
            n_checks++;
            if (q_obs_ar[i] !== wrap_seq[i]) begin
                n_errors++;
                $display("FAIL wrap_araddr[%0d]: got %0d, required %0d", i, q_obs_ar[i], wrap_seq[i]);
            end
        end
        n_checks++;
        if (q_obs_out.size() != q_exp_out.size()) begin
            n_errors++;
            $display("FAIL wrap_out_count: got %0d, required %0d", q_obs_out.size(), q_exp_out.size());
        end
        while (q_exp_out.size() != 0 && q_obs_out.size() != 0) begin
            eo = q_exp_out.pop_front();
            n_checks++;
            if (q_obs_out[0] !== eo) begin
                n_errors++;
                $display("FAIL wrap_out: got last=%0b data=%h, required last=%0b data=%h",
                         q_obs_out[0][DATA_W], q_obs_out[0][DATA_W-1:0], eo[DATA_W], eo[DATA_W-1:0]);
            end
            void'(q_obs_out.pop_front());
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [DATA_W:0] eo;
        logic [ADDR_W-1:0] ea;
        clear_all();
        out_ready = 1'b0;
        issue_cmd(6'd10, 7'd8, acc);
        repeat (20) tick();
        @(negedge clk);
        n_checks++;
        if (q_obs_ar.size() != FIFO_DEPTH || arvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_credit_stall: handshakes=%0d arvalid=%0b, required %0d and 0",
                     q_obs_ar.size(), arvalid, FIFO_DEPTH);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== word_of(6'd10)) begin
            n_errors++;
            $display("FAIL bp_head: valid=%0b data=%h, required 1 and %h", out_valid, out_data, word_of(6'd10));
        end
        tick();
        out_ready = 1'b1;
        wait_done(100, "bp");
        n_checks++;
        if (q_obs_ar.size() != 8 || q_obs_out.size() != 8) begin
            n_errors++;
            $display("FAIL bp_counts: ar=%0d out=%0d, required 8 and 8", q_obs_ar.size(), q_obs_out.size());
        end
        while (q_exp_ar.size() != 0 && q_obs_ar.size() != 0) begin
            ea = q_exp_ar.pop_front();
            n_checks++;
            if (q_obs_ar[0] !== ea) begin
                n_errors++;
                $display("FAIL bp_araddr: got %0d, required %0d", q_obs_ar[0], ea);
            end
            void'(q_obs_ar.pop_front());
        end
        while (q_exp_out.size() != 0 && q_obs_out.size() != 0) begin
            eo = q_exp_out.pop_front();
            n_checks++;
            if (q_obs_out[0] !== eo) begin
                n_errors++;
                $display("FAIL bp_out: got last=%0b data=%h, required last=%0b data=%h",
                         q_obs_out[0][DATA_W], q_obs_out[0][DATA_W-1:0], eo[DATA_W], eo[DATA_W-1:0]);
            end
            void'(q_obs_out.pop_front());
        end
    endtask

    task automatic test_ar_stall();
        int acc;
        logic [DATA_W:0] eo;
        clear_all();
        out_ready = 1'b1;
        arready = 1'b0;
        issue_cmd(6'd20, 7'd2, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== 6'd20) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: arvalid=%0b araddr=%0d, required 1 and 20", i, arvalid, araddr);
            end
            tick();
        end
        n_checks++;
        if (q_obs_ar.size() != 0) begin
            n_errors++;
            $display("FAIL stall_no_hs: handshakes=%0d, required 0", q_obs_ar.size());
        end
        arready = 1'b1;
        wait_done(50, "stall");
        n_checks++;
        if (q_obs_ar.size() != 2 || q_obs_ar[0] !== 6'd20 || q_obs_ar[1] !== 6'd21) begin
            n_errors++;
            $display("FAIL stall_ar_seq: count=%0d, required 2 requests at 20,21", q_obs_ar.size());
        end
        while (q_exp_out.size() != 0 && q_obs_out.size() != 0) begin
            eo = q_exp_out.pop_front();
            n_checks++;
            if (q_obs_out[0] !== eo) begin
                n_errors++;
                $display("FAIL stall_out: got last=%0b data=%h, required last=%0b data=%h",
                         q_obs_out[0][DATA_W], q_obs_out[0][DATA_W-1:0], eo[DATA_W], eo[DATA_W-1:0]);
            end
            void'(q_obs_out.pop_front());
        end
    endtask

    task automatic test_zero_len();
        int acc;
        int start;
        clear_all();
        start = done_cnt;
        issue_cmd(6'd7, 7'd0, acc);
        @(negedge clk);
        n_checks++;
        if ({done, cmd_ready, arvalid, busy} !== 4'b1001) begin
            n_errors++;
            $display("FAIL zero_done_cycle: done,cmd_ready,arvalid,busy=%b, required 1001",
                     {done, cmd_ready, arvalid, busy});
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({done, cmd_ready, busy} !== 3'b010) begin
            n_errors++;
            $display("FAIL zero_back_idle: done,cmd_ready,busy=%b, required 010", {done, cmd_ready, busy});
        end
        tick();
        n_checks++;
        if (q_obs_ar.size() != 0 || done_cnt != start + 1 || done_cyc != acc) begin
            n_errors++;
            $display("FAIL zero_summary: ar=%0d dones=%0d done_cyc=%0d, required 0, %0d, %0d",
                     q_obs_ar.size(), done_cnt - start, done_cyc, 1, acc);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int t;
        logic [DATA_W:0] eo;
        clear_all();
        arready = 1'b1;
        out_ready = 1'b1;
        issue_cmd(6'd30, 7'd6, acc);
        t = 0;
        while (q_obs_out.size() < 2 && t < 50) begin
            tick();
            t++;
        end
        n_checks++;
        if (q_obs_out.size() != 2) begin
            n_errors++;
            $display("FAIL rst_pre_words: got %0d, required 2", q_obs_out.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, arvalid, out_valid, out_last, busy, done, rready} !== 7'b1000001 || araddr !== '0) begin
            n_errors++;
            $display("FAIL rst_mid_values: ctrl=%b araddr=%0d, required 1000001 and 0",
                     {cmd_ready, arvalid, out_valid, out_last, busy, done, rready}, araddr);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        clear_all();
        repeat (5) tick();
        n_checks++;
        if (q_obs_out.size() != 0 || q_obs_ar.size() != 0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_post_quiet: out=%0d ar=%0d out_valid=%0b, required 0 0 0",
                     q_obs_out.size(), q_obs_ar.size(), out_valid);
        end
        issue_cmd(6'd0, 7'd2, acc);
        wait_done(50, "rst_new");
        n_checks++;
        if (q_obs_out.size() != 2) begin
            n_errors++;
            $display("FAIL rst_new_count: got %0d, required 2", q_obs_out.size());
        end
        while (q_exp_out.size() != 0 && q_obs_out.size() != 0) begin
            eo = q_exp_out.pop_front();
            n_checks++;
            if (q_obs_out[0] !== eo) begin
                n_errors++;
                $display("FAIL rst_new_out: got last=%0b data=%h, required last=%0b data=%h",
                         q_obs_out[0][DATA_W], q_obs_out[0][DATA_W-1:0], eo[DATA_W], eo[DATA_W-1:0]);
            end
            void'(q_obs_out.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_ar_stall();
        test_zero_len();
        test_reset_mid_burst();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
